// File: rtl/rt_req_hold_if.sv
// Handshake bundle between the routing unit, the route request holder and the allocator.
// master drives routes/grants/tail events; slave is the holder presenting requests and paths.
interface rt_req_hold_if #(
  parameter int VCN = 2,
  parameter int SN  = 4,
  parameter int WCW = 8
);
  logic [VCN-1:0]     rt_vld;
  logic [VCN*SN-1:0]  rt_dir;
  logic [VCN-1:0]     rt_rdy;
  logic [VCN*SN-1:0]  req;
  logic [VCN-1:0]     gnt;
  logic [VCN-1:0]     tail_out;
  logic [VCN*SN-1:0]  path;
  logic [VCN*WCW-1:0] wait_cnt;
  logic [VCN-1:0]     err;

  modport master (
    output rt_vld, rt_dir, gnt, tail_out,
    input  rt_rdy, req, path, wait_cnt, err
  );

  modport slave (
    input  rt_vld, rt_dir, gnt, tail_out,
    output rt_rdy, req, path, wait_cnt, err
  );
endinterface

// File: rtl/rt_req_hold.sv
// Per-VC route request holder between routing calculation and switch/VC allocation.
// Define RT_ONEHOT_CHK_EN to reject non-one-hot routes and raise a sticky per-VC err.
module rt_req_hold #(
  parameter int VCN = 2,
  parameter int SN  = 4,
  parameter int WCW = 8
) (
  input logic          clk,
  input logic          rst_n,
  rt_req_hold_if.slave bus
);
  // state  | meaning
  // IDLE   | VC free, rt_rdy high, waiting for a route decision
  // REQ    | route held, request shown to allocator, wait counter running
  // ACTIVE | granted, path reserved until the packet's tail flit leaves
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  logic [VCN-1:0]     rdy_bits;
  logic [VCN-1:0]     err_bits;
  logic [VCN*SN-1:0]  req_bits;
  logic [VCN*SN-1:0]  path_bits;
  logic [VCN*WCW-1:0] cnt_bits;

  for (genvar v = 0; v < VCN; v++) begin : g_vc
    logic [1:0]     state;
    logic [SN-1:0]  dir_q;
    logic [SN-1:0]  dir_in;
    logic [WCW-1:0] cnt;
    logic           route_ok;

    assign dir_in = bus.rt_dir[v*SN +: SN];

`ifdef RT_ONEHOT_CHK_EN
    logic err_q;

    assign route_ok = $onehot(dir_in);

    // A malformed route is still consumed; only the flag records it.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        err_q <= 1'b0;
      end else if (state == ST_IDLE && bus.rt_vld[v] && !route_ok) begin
        err_q <= 1'b1;
      end
    end

    assign err_bits[v] = err_q;
`else
    assign route_ok    = 1'b1;
    assign err_bits[v] = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= ST_IDLE;
        dir_q <= '0;
        cnt   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.rt_vld[v] && route_ok) begin
              state <= ST_REQ;
              dir_q <= dir_in;
              cnt   <= '0;
            end
          end
          ST_REQ: begin
            if (cnt != {WCW{1'b1}}) cnt <= cnt + 1'b1;
            if (bus.gnt[v]) state <= ST_ACTIVE;
          end
          ST_ACTIVE: begin
            if (bus.tail_out[v]) begin
              state <= ST_IDLE;
              dir_q <= '0;
              cnt   <= '0;
            end
          end
          default: begin
            state <= ST_IDLE;
            dir_q <= '0;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign rdy_bits[v]                = (state == ST_IDLE);
    assign req_bits[v*SN +: SN]       = (state == ST_REQ)    ? dir_q : '0;
    assign path_bits[v*SN +: SN]      = (state == ST_ACTIVE) ? dir_q : '0;
    assign cnt_bits[v*WCW +: WCW]     = cnt;
  end

  assign bus.rt_rdy   = rdy_bits;
  assign bus.req      = req_bits;
  assign bus.path     = path_bits;
  assign bus.wait_cnt = cnt_bits;
  assign bus.err      = err_bits;
endmodule

// File: tb/tb_rt_req_hold.sv
// Directed and randomized checks of rt_req_hold against a per-VC packet-lifecycle model.
module tb_rt_req_hold;
  localparam int VCN  = 2;
  localparam int SN   = 4;
  localparam int WCW  = 3;
  localparam int WMAX = (1 << WCW) - 1;
`ifdef RT_ONEHOT_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;

  rt_req_hold_if #(.VCN(VCN), .SN(SN), .WCW(WCW)) bus ();

  rt_req_hold #(.VCN(VCN), .SN(SN), .WCW(WCW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Model: has_route = a route is held, granted = allocator said yes, waited = REQ cycles seen.
  bit            has_route [VCN];
  bit            granted   [VCN];
  logic [SN-1:0] m_dir     [VCN];
  int            waited    [VCN];
  bit            m_err     [VCN];

  function automatic int ones(logic [SN-1:0] d);
    int n = 0;
    for (int i = 0; i < SN; i++) n += int'(d[i]);
    return n;
  endfunction

  task automatic model_clear();
    for (int v = 0; v < VCN; v++) begin
      has_route[v] = 1'b0;
      granted[v]   = 1'b0;
      m_dir[v]     = '0;
      waited[v]    = 0;
      m_err[v]     = 1'b0;
    end
  endtask

  task automatic model_edge();
    logic [SN-1:0] d;
    for (int v = 0; v < VCN; v++) begin
      d = bus.rt_dir[v*SN +: SN];
      if (!has_route[v]) begin
        if (bus.rt_vld[v]) begin
          if (CHK && ones(d) != 1) begin
            m_err[v] = 1'b1;
          end else begin
            has_route[v] = 1'b1;
            granted[v]   = 1'b0;
            m_dir[v]     = d;
            waited[v]    = 0;
          end
        end
      end else if (!granted[v]) begin
        waited[v]++;
        if (bus.gnt[v]) granted[v] = 1'b1;
      end else if (bus.tail_out[v]) begin
        has_route[v] = 1'b0;
        granted[v]   = 1'b0;
        m_dir[v]     = '0;
        waited[v]    = 0;
      end
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    logic [SN-1:0] e_req, e_path;
    int e_wait;
    for (int v = 0; v < VCN; v++) begin
      e_req  = (has_route[v] && !granted[v]) ? m_dir[v] : '0;
      e_path = (has_route[v] && granted[v])  ? m_dir[v] : '0;
      e_wait = (waited[v] > WMAX) ? WMAX : waited[v];
      check($sformatf("%s_rdy%0d", tag, v),  32'(bus.rt_rdy[v]), 32'(!has_route[v]));
      check($sformatf("%s_req%0d", tag, v),  32'(bus.req[v*SN +: SN]), 32'(e_req));
      check($sformatf("%s_path%0d", tag, v), 32'(bus.path[v*SN +: SN]), 32'(e_path));
      check($sformatf("%s_wait%0d", tag, v), 32'(bus.wait_cnt[v*WCW +: WCW]), 32'(e_wait));
      check($sformatf("%s_err%0d", tag, v),  32'(bus.err[v]), 32'(m_err[v]));
    end
  endtask

  task automatic step(string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  bit            pend  [VCN];
  logic [SN-1:0] pdir  [VCN];
  bit            taken [VCN];

  initial begin
    bus.rt_vld   = '0;
    bus.rt_dir   = '0;
    bus.gnt      = '0;
    bus.tail_out = '0;
    model_clear();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic packet on VC1: accept at edge 0, grant at edge 4, tail at edge 8.
    bus.rt_vld = 2'b10;
    bus.rt_dir = 8'b0100_0000;
    step("acc1");
    bus.rt_vld = '0;
    check("basic_req", 32'(bus.req[7:4]), 32'h4);
    check("basic_w0", 32'(bus.wait_cnt[5:3]), 32'd0);
    for (int i = 0; i < 3; i++) step("req1");
    check("basic_w3", 32'(bus.wait_cnt[5:3]), 32'd3);
    bus.gnt = 2'b10;
    step("gnt1");
    bus.gnt = '0;
    check("basic_path", 32'(bus.path[7:4]), 32'h4);
    check("basic_req_off", 32'(bus.req[7:4]), 32'h0);
    for (int i = 0; i < 3; i++) step("act1");
    bus.tail_out = 2'b10;
    step("tail1");
    bus.tail_out = '0;
    check("basic_rdy", 32'(bus.rt_rdy[1]), 32'd1);

    // Grant while idle is ignored; tail while requesting is ignored; counter saturates.
    bus.gnt = 2'b10;
    step("gnt_idle");
    bus.gnt = '0;
    check("gnt_idle_rdy", 32'(bus.rt_rdy[1]), 32'd1);
    bus.rt_vld = 2'b01;
    bus.rt_dir = 8'b0000_0001;
    step("acc0");
    bus.rt_vld = '0;
    bus.tail_out = 2'b01;
    step("tail_req");
    bus.tail_out = '0;
    check("tail_req_hold", 32'(bus.req[3:0]), 32'h1);
    for (int i = 0; i < 18; i++) step("sat");
    check("sat_wait", 32'(bus.wait_cnt[2:0]), 32'd7);

    // VC1 to ACTIVE; new route while active is ignored.
    bus.rt_vld = 2'b10;
    bus.rt_dir = 8'b1000_0001;
    step("acc1b");
    bus.gnt = 2'b10;
    bus.rt_vld = '0;
    step("gnt1b");
    bus.gnt = '0;
    bus.rt_vld = 2'b10;
    bus.rt_dir = 8'b0010_0001;
    step("vld_act");
    bus.rt_vld = '0;
    check("vld_act_path", 32'(bus.path[7:4]), 32'h8);
    check("vld_act_rdy", 32'(bus.rt_rdy[1]), 32'd0);

    // Same-cycle grant on VC0 and tail on VC1.
    bus.gnt = 2'b01;
    bus.tail_out = 2'b10;
    step("indep");
    bus.gnt = '0;
    bus.tail_out = '0;
    check("indep_path0", 32'(bus.path[3:0]), 32'h1);
    check("indep_rdy1", 32'(bus.rt_rdy[1]), 32'd1);
    check("indep_path1", 32'(bus.path[7:4]), 32'h0);

    // Grant and tail together in REQ: grant wins.
    bus.rt_vld = 2'b10;
    bus.rt_dir = 8'b0010_0000;
    step("acc1c");
    bus.rt_vld = '0;
    bus.gnt = 2'b10;
    bus.tail_out = 2'b10;
    step("gnt_tail");
    bus.gnt = '0;
    bus.tail_out = '0;
    check("gnt_tail_path", 32'(bus.path[7:4]), 32'h2);

    // Asynchronous reset with VC0 and VC1 both active.
    rst_n = 1'b0;
    model_clear();
    #1;
    check("rst_rdy", 32'(bus.rt_rdy), 32'h3);
    check("rst_req", 32'(bus.req), 32'h0);
    check("rst_path", 32'(bus.path), 32'h0);
    check("rst_wait", 32'(bus.wait_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Malformed route on VC0.
    bus.rt_vld = 2'b01;
    bus.rt_dir = 8'b0000_0110;
    step("bad");
    bus.rt_vld = '0;
`ifdef RT_ONEHOT_CHK_EN
    check("bad_rdy", 32'(bus.rt_rdy[0]), 32'd1);
    check("bad_req", 32'(bus.req[3:0]), 32'h0);
    check("bad_err", 32'(bus.err[0]), 32'd1);
    step("bad_hold");
    step("bad_hold");
    check("bad_err_sticky", 32'(bus.err[0]), 32'd1);
`else
    check("bad_req", 32'(bus.req[3:0]), 32'h6);
    check("bad_err", 32'(bus.err[0]), 32'd0);
`endif

    // Randomized traffic: routing unit holds each request until accepted.
    for (int v = 0; v < VCN; v++) pend[v] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int v = 0; v < VCN; v++) begin
        if (!pend[v] && $urandom_range(0, 2) == 0) begin
          pend[v] = 1'b1;
          if ($urandom_range(0, 7) == 0) pdir[v] = SN'($urandom_range(0, (1 << SN) - 1));
          else pdir[v] = SN'(1) << $urandom_range(0, SN - 1);
        end
        bus.rt_vld[v]            = pend[v];
        bus.rt_dir[v*SN +: SN]   = pdir[v];
        bus.gnt[v]               = ($urandom_range(0, 3) == 0);
        bus.tail_out[v]          = ($urandom_range(0, 3) == 0);
        taken[v]                 = pend[v] && !has_route[v];
      end
      step("rnd");
      for (int v = 0; v < VCN; v++) if (taken[v]) pend[v] = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
